// File: rtl/decode_pkg.sv
// Shared definitions for the RV32/RV64 decode stage: base opcode table,
// instruction format enum and the XLEN-independent decoded field bundle.
// Ports: none (package).
package decode_pkg;

  // Major opcodes recognised by the decoder (inst[6:0]).
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // func7 values accepted on OP / OP-32.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_e;

  // Decoded fields that do not depend on XLEN; imm and pc travel beside it.
  typedef struct packed {
    logic [6:0] func7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] func3;
    logic [4:0] rd;
    logic [6:0] opcode;
    fmt_e       fmt;
    logic       illegal;
  } dec_t;

  localparam dec_t DEC_RESET = '{
    func7:   7'd0,
    rs2:     5'd0,
    rs1:     5'd0,
    func3:   3'd0,
    rd:      5'd0,
    opcode:  7'd0,
    fmt:     FMT_NONE,
    illegal: 1'b0
  };

  function automatic logic func7_ok(input logic [6:0] f7, input logic en_m);
    return (f7 == F7_BASE) || (f7 == F7_ALT) || (en_m && (f7 == F7_MULDIV));
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational decoder: field extraction, format classification, illegal
// detection and XLEN-wide sign-extended immediate.
// Ports: inst_i (raw 32-bit instruction) -> dec_o (field bundle), imm_o (XLEN).
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int EN_M = 1,
  parameter int EN_W = 0
) (
  input  logic [31:0]     inst_i,
  output dec_t            dec_o,
  output logic [XLEN-1:0] imm_o
);

  // W opcodes only exist on a 64-bit core that opts in.
  localparam logic W_OK  = (EN_W != 0) && (XLEN == 64);
  localparam logic M_OK  = (EN_M != 0);

  logic [6:0]  opc;
  logic [6:0]  f7;
  fmt_e        fmt;
  logic        ill;
  logic [31:0] imm32;

  assign opc = inst_i[6:0];
  assign f7  = inst_i[31:25];

  always_comb begin
    fmt = FMT_NONE;
    ill = 1'b0;
    if (inst_i[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (opc)
        OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
        OPC_OP_IMM_32: begin
          if (W_OK) fmt = FMT_I;
          else      ill = 1'b1;
        end
        OPC_STORE:           fmt = FMT_S;
        OPC_BRANCH:          fmt = FMT_B;
        OPC_LUI, OPC_AUIPC:  fmt = FMT_U;
        OPC_JAL:             fmt = FMT_J;
        // Fences are legal but carry no immediate the pipeline uses.
        OPC_MISC_MEM:        fmt = FMT_NONE;
        OPC_OP: begin
          if (func7_ok(f7, M_OK)) fmt = FMT_R;
          else                    ill = 1'b1;
        end
        OPC_OP_32: begin
          if (W_OK && func7_ok(f7, M_OK)) fmt = FMT_R;
          else                            ill = 1'b1;
        end
        default: ill = 1'b1;
      endcase
    end
  end

  // Illegal encodings leave fmt at NONE, so they fall through to imm=0.
  always_comb begin
    imm32 = 32'd0;
    case (fmt)
      FMT_I: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      FMT_S: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      FMT_B: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                      inst_i[11:8], 1'b0};
      FMT_U: imm32 = {inst_i[31:12], 12'd0};
      FMT_J: imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                      inst_i[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  // All formats are 32-bit sign-extended values; widen from bit 31.
  assign imm_o = XLEN'($signed(imm32));

  assign dec_o = '{
    func7:   inst_i[31:25],
    rs2:     inst_i[24:20],
    rs1:     inst_i[19:15],
    func3:   inst_i[14:12],
    rd:      inst_i[11:7],
    opcode:  inst_i[6:0],
    fmt:     fmt,
    illegal: ill
  };

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: output register plus one skid entry, 1-cycle latency.
// Ports: clk/rst, flush, in_valid/in_ready/in_inst/in_pc upstream,
// out_valid/out_ready and decoded out_* fields downstream.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int EN_M = 1,
  parameter int EN_W = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_func3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_func7,
  output logic [XLEN-1:0] out_imm,
  output fmt_e            out_fmt,
  output logic            out_illegal
);

  dec_t            in_dec;
  logic [XLEN-1:0] in_imm;

  imm_gen #(
    .XLEN (XLEN),
    .EN_M (EN_M),
    .EN_W (EN_W)
  ) u_imm_gen (
    .inst_i (in_inst),
    .dec_o  (in_dec),
    .imm_o  (in_imm)
  );

  // Output register (OR) and skid entry (SK).
  logic            or_vld_q, or_vld_d;
  dec_t            or_dec_q, or_dec_d;
  logic [XLEN-1:0] or_imm_q, or_imm_d;
  logic [XLEN-1:0] or_pc_q,  or_pc_d;
  logic            sk_vld_q, sk_vld_d;
  dec_t            sk_dec_q, sk_dec_d;
  logic [XLEN-1:0] sk_imm_q, sk_imm_d;
  logic [XLEN-1:0] sk_pc_q,  sk_pc_d;

  logic xfer;
  logic accept;
  logic or_load;

  // Ready depends only on the skid flag, so out_ready never reaches in_ready.
  assign in_ready = !sk_vld_q;
  assign xfer     = or_vld_q && out_ready;
  assign accept   = in_valid && in_ready;
  assign or_load  = !or_vld_q || xfer;

  always_comb begin
    or_vld_d = or_vld_q;
    or_dec_d = or_dec_q;
    or_imm_d = or_imm_q;
    or_pc_d  = or_pc_q;
    sk_vld_d = sk_vld_q;
    sk_dec_d = sk_dec_q;
    sk_imm_d = sk_imm_q;
    sk_pc_d  = sk_pc_q;
    if (flush) begin
      // Any transfer this cycle already completed; everything else is dropped.
      or_vld_d = 1'b0;
      sk_vld_d = 1'b0;
    end else if (or_load) begin
      if (sk_vld_q) begin
        // in_ready is low while the skid is full, so no input competes here.
        or_vld_d = 1'b1;
        or_dec_d = sk_dec_q;
        or_imm_d = sk_imm_q;
        or_pc_d  = sk_pc_q;
        sk_vld_d = 1'b0;
      end else begin
        or_vld_d = accept;
        if (accept) begin
          or_dec_d = in_dec;
          or_imm_d = in_imm;
          or_pc_d  = in_pc;
        end
      end
    end else if (accept) begin
      // OR is stalled: park the instruction that was already in flight.
      sk_vld_d = 1'b1;
      sk_dec_d = in_dec;
      sk_imm_d = in_imm;
      sk_pc_d  = in_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_vld_q <= 1'b0;
      or_dec_q <= DEC_RESET;
      or_imm_q <= '0;
      or_pc_q  <= '0;
      sk_vld_q <= 1'b0;
      sk_dec_q <= DEC_RESET;
      sk_imm_q <= '0;
      sk_pc_q  <= '0;
    end else begin
      or_vld_q <= or_vld_d;
      or_dec_q <= or_dec_d;
      or_imm_q <= or_imm_d;
      or_pc_q  <= or_pc_d;
      sk_vld_q <= sk_vld_d;
      sk_dec_q <= sk_dec_d;
      sk_imm_q <= sk_imm_d;
      sk_pc_q  <= sk_pc_d;
    end
  end

  assign out_valid   = or_vld_q;
  assign out_pc      = or_pc_q;
  assign out_imm     = or_imm_q;
  assign out_opcode  = or_dec_q.opcode;
  assign out_rd      = or_dec_q.rd;
  assign out_func3   = or_dec_q.func3;
  assign out_rs1     = or_dec_q.rs1;
  assign out_rs2     = or_dec_q.rs2;
  assign out_func7   = or_dec_q.func7;
  assign out_fmt     = or_dec_q.fmt;
  assign out_illegal = or_dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  import decode_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // 32-bit instance
  logic        flush = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [31:0] in_inst = '0, in_pc = '0, out_pc, out_imm;
  logic [6:0]  out_opcode, out_func7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_func3;
  fmt_e        out_fmt;
  logic        out_illegal;

  decode_stage #(.XLEN(32), .EN_M(1), .EN_W(0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_func3(out_func3),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_func7(out_func7),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  // 64-bit instance without W opcodes
  logic        in_valid64 = 1'b0, in_ready64, out_valid64, out_ready64 = 1'b1;
  logic [31:0] in_inst64 = '0;
  logic [63:0] in_pc64 = '0, out_pc64, out_imm64;
  logic [6:0]  out_opcode64, out_func7_64;
  logic [4:0]  out_rd64, out_rs1_64, out_rs2_64;
  logic [2:0]  out_func3_64;
  fmt_e        out_fmt64;
  logic        out_illegal64;

  decode_stage #(.XLEN(64), .EN_M(1), .EN_W(0)) dut64 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_inst(in_inst64), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_pc(out_pc64),
    .out_opcode(out_opcode64), .out_rd(out_rd64), .out_func3(out_func3_64),
    .out_rs1(out_rs1_64), .out_rs2(out_rs2_64), .out_func7(out_func7_64),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    fmt_e        fmt;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_err = 0;
  int   n_chk = 0;
  int   stalls = 0;
  int   delivered = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_output: got pc %h with nothing expected", out_pc);
      end else begin
        exp_t e;
        logic [31:0] ins;
        e = exp_q.pop_front();
        ins = e.inst;
        delivered++;
        chk("out_pc",      out_pc,      e.pc);
        chk("out_imm",     out_imm,     e.imm);
        chk("out_fmt",     out_fmt,     e.fmt);
        chk("out_illegal", out_illegal, e.ill);
        chk("out_fields",  {out_func7, out_rs2, out_rs1, out_func3, out_rd, out_opcode}, ins);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, wait (bounded) for acceptance, and expect it.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] imm, input fmt_e fmt, input logic ill);
    exp_t e;
    int   w;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    w = 0;
    while (!in_ready && w < 50) begin
      step();
      w++;
      stalls++;
    end
    if (!in_ready) begin
      n_chk++;
      n_err++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end
    e.inst = inst; e.pc = pc; e.imm = imm; e.fmt = fmt; e.ill = ill;
    exp_q.push_back(e);
    step();
  endtask

  // Present an instruction that is expected to be discarded later.
  task automatic drive_raw(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    step();
  endtask

  int s0;

  initial begin
    // Reset state
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc",    out_pc, 0);
    chk("rst_out_imm",   out_imm, 0);
    chk("rst_out_fmt",   out_fmt, FMT_NONE);
    chk("rst_out_rd",    out_rd, 0);
    rst = 1'b0;
    step();
    chk("rst_in_ready",  in_ready, 1);

    // Back-to-back stream at full rate
    out_ready = 1'b1;
    s0 = stalls;
    send(32'hFFF10093, 32'h100, 32'hFFFFFFFF, FMT_I,    1'b0); // addi x1,x2,-1
    send(32'h00512423, 32'h104, 32'h00000008, FMT_S,    1'b0); // sw x5,8(x2)
    send(32'hFE000EE3, 32'h108, 32'hFFFFFFFC, FMT_B,    1'b0); // beq x0,x0,-4
    send(32'h001000EF, 32'h10C, 32'h00000800, FMT_J,    1'b0); // jal x1,2048
    send(32'h02208033, 32'h110, 32'h00000000, FMT_R,    1'b0); // mul x0,x1,x2
    send(32'h04000033, 32'h114, 32'h00000000, FMT_NONE, 1'b1); // bad func7
    send(32'h00000001, 32'h118, 32'h00000000, FMT_NONE, 1'b1); // compressed
    send(32'h0000003B, 32'h11C, 32'h00000000, FMT_NONE, 1'b1); // addw on RV32
    send(32'h0000000F, 32'h120, 32'h00000000, FMT_NONE, 1'b0); // fence
    send(32'h12345037, 32'h124, 32'h12345000, FMT_U,    1'b0); // lui x0,0x12345
    in_valid = 1'b0;
    chk("stream_no_stall", stalls - s0, 0);
    step(); step();

    // Back-pressure: A held, B in skid, C stalled upstream
    out_ready = 1'b0;
    send(32'h00A00093, 32'h200, 32'h0000000A, FMT_I, 1'b0);    // A: addi x1,x0,10
    send(32'h00B00113, 32'h204, 32'h0000000B, FMT_I, 1'b0);    // B: addi x2,x0,11
    in_valid = 1'b1;
    in_inst  = 32'h00C00193;                                   // C: addi x3,x0,12
    in_pc    = 32'h208;
    for (int i = 0; i < 3; i++) begin
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_pc",    out_pc, 32'h200);
      chk("stall_out_imm",   out_imm, 32'h0000000A);
      chk("stall_in_ready",  in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    send(32'h00C00193, 32'h208, 32'h0000000C, FMT_I, 1'b0);
    in_valid = 1'b0;
    step(); step(); step();
    chk("stall_drained", exp_q.size(), 0);

    // Flush with skid full and a new input presented
    out_ready = 1'b0;
    drive_raw(32'h00100093, 32'h300);
    drive_raw(32'h00200093, 32'h304);
    chk("flush_pre_in_ready", in_ready, 0);
    in_inst = 32'h00300093;
    in_pc   = 32'h308;
    flush   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready",  in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("flush_nothing_out", out_valid, 0);

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    drive_raw(32'hFFF10093, 32'h400);
    drive_raw(32'h00512423, 32'h404);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid",   out_valid, 0);
    chk("arst_out_imm",     out_imm, 0);
    chk("arst_out_pc",      out_pc, 0);
    chk("arst_out_fields",  {out_func7, out_rs2, out_rs1, out_func3, out_rd, out_opcode}, 0);
    chk("arst_out_fmt",     out_fmt, FMT_NONE);
    chk("arst_out_illegal", out_illegal, 0);
    step();
    rst = 1'b0;
    step();
    out_ready = 1'b1;
    send(32'hFFF10093, 32'h500, 32'hFFFFFFFF, FMT_I, 1'b0);
    in_valid = 1'b0;
    step(); step();

    // RV64 instance: U sign extension and W opcode without EN_W
    in_valid64 = 1'b1;
    in_inst64  = 32'h800000B7;          // lui x1,0x80000
    in_pc64    = 64'h8000_0000_0000_0010;
    step();
    chk("rv64_lui_valid", out_valid64, 1);
    chk("rv64_lui_imm",   out_imm64, 64'hFFFFFFFF80000000);
    chk("rv64_lui_fmt",   out_fmt64, FMT_U);
    chk("rv64_lui_ill",   out_illegal64, 0);
    chk("rv64_lui_rd",    out_rd64, 1);
    chk("rv64_lui_pc",    out_pc64, 64'h8000_0000_0000_0010);
    in_inst64 = 32'h0000003B;           // addw x0,x0,x0
    in_pc64   = 64'h8000_0000_0000_0014;
    step();
    chk("rv64_addw_ill", out_illegal64, 1);
    chk("rv64_addw_fmt", out_fmt64, FMT_NONE);
    chk("rv64_addw_imm", out_imm64, 0);
    in_valid64 = 1'b0;
    step(); step();

    chk("queue_empty", exp_q.size(), 0);
    chk("delivered",   delivered, 14);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32/RV64 instruction decode stage between fetch and execute.
- Extracts register fields, generates the XLEN-wide sign-extended immediate, and classifies the instruction format.
- Flags illegal encodings and passes the PC through.
- Valid/ready handshake on both sides, a two-entry skid buffer for full throughput, and a synchronous flush for branch redirect.

Parameters:
- XLEN, 32, datapath width for immediate and PC (32 or 64).
- EN_M, 1, when 1, func7=0000001 on OP/OP-32 is legal (M extension).
- EN_W, 0, when 1 and XLEN=64, OP-IMM-32 (0011011) and OP-32 (0111011) are legal.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  discard all held and incoming instructions this cycle.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept.
- in_inst  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  XLEN  passthrough PC.
- out_opcode  out  7  inst[6:0].
- out_rd  out  5  inst[11:7].
- out_func3  out  3  inst[14:12].
- out_rs1  out  5  inst[19:15].
- out_rs2  out  5  inst[24:20].
- out_func7  out  7  inst[31:25].
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  fmt_e: R, I, S, B, U, J, NONE.
- out_illegal  out  1  illegal encoding.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0; skid entry empty.
  - All out_* data fields are 0; out_fmt=NONE.
  - in_ready=1 once rst deasserts.
- Latency: 1 cycle. An instruction accepted at edge N appears on out_* after edge N.
- in_ready = !skid_valid. It is registered-derived, with no combinational path from out_ready.
- Output register (OR) behaviour:
  - Transfer occurs when out_valid && out_ready.
  - OR loads when empty or transferring.
  - Load source is the skid entry if occupied, else the incoming instruction.
  - If in_valid && in_ready while OR is occupied and not transferring, the decoded input goes to the skid entry.
- Stability: while out_valid && !out_ready, all out_* fields hold bit-stable.
- Flush (synchronous, highest priority):
  - Next cycle out_valid=0 and skid empty.
  - An input presented the same cycle is dropped.
  - A transfer occurring the same cycle still counts as delivered.
- Immediate generation:
  - I format (OP-IMM, LOAD, JALR, OP-IMM-32, SYSTEM): sext(inst[31:20]).
  - S format: sext({inst[31:25], inst[11:7]}).
  - B format: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - U format (LUI, AUIPC): sext({inst[31:12], 12'b0}), sign-extended from bit 31 when XLEN=64.
  - J format: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - R format, NONE, MISC-MEM: imm=0.
- Illegal (out_illegal=1, out_fmt=NONE, imm=0) when any of:
  - inst[1:0] != 2'b11.
  - Opcode not in the package table.
  - OP/OP-32 func7 not in {0000000, 0100000, 0000001 if EN_M}.
  - W opcodes present without EN_W && XLEN=64.
  - Illegal instructions still flow through the handshake normally. They are never dropped.
- Throughput: one instruction per cycle sustained while out_ready=1.
- Back-pressure: absorbs exactly one extra instruction after out_ready falls.

Decomposition:
- decode_pkg holds:
  - Opcode constants: OPC_LOAD 0000011, OPC_MISC_MEM 0001111, OPC_OP_IMM 0010011, OPC_AUIPC 0010111, OPC_OP_IMM_32 0011011, OPC_STORE 0100011, OPC_OP 0110011, OPC_LUI 0110111, OPC_OP_32 0111011, OPC_BRANCH 1100011, OPC_JALR 1100111, OPC_JAL 1101111, OPC_SYSTEM 1110011.
  - fmt_e enum.
  - A packed struct for the decoded bundle.
- One combinational sub-module, imm_gen (params XLEN, EN_M, EN_W), produces imm, fmt and illegal.
- decode_stage contains only the skid/output registers and the handshake logic.

Test Plan:
- XLEN=32, in 0xFFF10093 (addi x1,x2,-1), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=2, imm=0xFFFFFFFF, fmt=I, illegal=0.
- 0x00512423 (sw x5,8(x2)), then 0xFE000EE3 (beq x0,x0,-4), then 0x001000EF (jal x1,2048) back-to-back -> imm 0x00000008 (S), 0xFFFFFFFC (B), 0x00000800 (J), one per cycle.
- XLEN=64, 0x800000B7 (lui x1,0x80000) -> imm=0xFFFFFFFF80000000, fmt=U. Then 0x0000003B (addw) with EN_W=0 -> illegal=1.
- out_ready=0 for 3 cycles while streaming A,B,C -> A held stable, B in skid, in_ready=0, C stalled upstream. Then release out_ready -> A,B,C each delivered exactly once, in order.
- Skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing delivered afterward.
- Assert rst mid-stall -> out_valid falls asynchronously, all out fields 0. After release, the first new instruction decodes correctly.
